// File: rtl/wb_timer.sv
// Machine timer (64-bit mtime/mtimecmp) on a Wishbone classic-cycle slave port, with level irq.
// Latency: ACK/ERR and DAT_O are registered at the acceptance edge; irq follows register state by one cycle.
// Backpressure: none. Every accepted access completes in one cycle, so back-to-back accesses take two cycles each.
module wb_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STB,
    input  logic        CYC,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    input  logic        WE,
    input  logic [2:0]  CTI_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY,
    output logic        irq
);

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [31:0]           hi_shadow;
    logic                  cnt_en;
    logic                  irq_en;
    logic [PRESCALE_W-1:0] div;
    logic [PRESCALE_W-1:0] pcnt;

    logic [2:0]  word;
    logic        accept;
    logic        bad;
    logic        good_acc;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        rd_lo;
    logic        tick;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_mux;

    // Upper address bits are decoded externally and the cycle type is ignored.
    logic unused_bits;
    assign unused_bits = ^{ADR[31:5], CTI_I};

    assign RTY = 1'b0;

    assign word      = ADR[4:2];
    assign accept    = STB & CYC & ~ACK & ~ERR;
    assign bad       = (ADR[1:0] != 2'b00) || (word > OFF_CTRL);
    assign good_acc  = accept & ~bad;
    assign wr_lo     = good_acc & WE & (word == OFF_MTIME_LO);
    assign wr_hi     = good_acc & WE & (word == OFF_MTIME_HI);
    assign wr_cmp_lo = good_acc & WE & (word == OFF_MTIMECMP_LO);
    assign wr_cmp_hi = good_acc & WE & (word == OFF_MTIMECMP_HI);
    assign wr_ctrl   = good_acc & WE & (word == OFF_CTRL);
    assign rd_lo     = good_acc & ~WE & (word == OFF_MTIME_LO);
    assign tick      = cnt_en & (pcnt == div);

    // Register read mux; CTRL bits outside cnt_en/irq_en/div read as zero.
    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[0]              = cnt_en;
        ctrl_rd[1]              = irq_en;
        ctrl_rd[8 +: PRESCALE_W] = div;
        rd_mux                  = '0;
        case (word)
            OFF_MTIME_LO:    rd_mux = mtime[31:0];
            OFF_MTIME_HI:    rd_mux = hi_shadow;
            OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            OFF_CTRL:        rd_mux = ctrl_rd;
            default:         rd_mux = '0;
        endcase
    end

    // Single-cycle bus response; it self-clears because a pending ACK/ERR blocks acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ACK   <= 1'b0;
            ERR   <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK   <= good_acc;
            ERR   <= accept & bad;
            DAT_O <= (good_acc & ~WE) ? rd_mux : '0;
        end
    end

    // Software-visible control, compare and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp  <= '1;
            hi_shadow <= '0;
            cnt_en    <= 1'b1;
            irq_en    <= 1'b0;
            div       <= '0;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= DAT_I;
            if (wr_cmp_hi) mtimecmp[63:32] <= DAT_I;
            if (wr_ctrl) begin
                cnt_en <= DAT_I[0];
                irq_en <= DAT_I[1];
                div    <= DAT_I[8 +: PRESCALE_W];
            end
            if (rd_lo) hi_shadow <= mtime[63:32];
        end
    end

    // Prescaler; a CTRL write restarts the divide period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (wr_ctrl || tick) begin
            pcnt <= '0;
        end else if (cnt_en) begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

    // mtime: a software write to either half wins over the tick and blocks the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) mtime[31:0]  <= DAT_I;
            if (wr_hi) mtime[63:32] <= DAT_I;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Registered level interrupt from the unsigned 64-bit compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: hand-computed expectations, one task per feature.
// Latency: each bus access is accepted on the first rising edge after it is driven.
// Backpressure: STB is held through the cycle after acceptance to show ACK/ERR self-clearing.
module tb_wb_timer;

    logic        clk;
    logic        rst;
    logic        STB;
    logic        CYC;
    logic [31:0] ADR;
    logic [31:0] DAT_I;
    logic        WE;
    logic [2:0]  CTI_I;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        ERR;
    logic        RTY;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rd;
    logic        a1, e1, a2, e2, i1, i2;

    wb_timer #(.PRESCALE_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .STB   (STB),
        .CYC   (CYC),
        .ADR   (ADR),
        .DAT_I (DAT_I),
        .WE    (WE),
        .CTI_I (CTI_I),
        .DAT_O (DAT_O),
        .ACK   (ACK),
        .ERR   (ERR),
        .RTY   (RTY),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // One access: drive at a negedge, accept at the next posedge (N), sample after N and N+1.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rdat, output logic ack1, output logic err1,
                       output logic ack2, output logic err2, output logic irq1, output logic irq2);
        STB = 1'b1; CYC = 1'b1; WE = we; ADR = adr; DAT_I = wd;
        @(posedge clk); #1;
        rdat = DAT_O; ack1 = ACK; err1 = ERR; irq1 = irq;
        @(posedge clk); #1;
        ack2 = ACK; err2 = ERR; irq2 = irq;
        @(negedge clk);
        STB = 1'b0; CYC = 1'b0; WE = 1'b0; ADR = '0; DAT_I = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; STB = 0; CYC = 0; WE = 0; ADR = '0; DAT_I = '0; CTI_I = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", ACK); end
        n_cmp++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", ERR); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
        n_cmp++; if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h expected 0", DAT_O); end
        n_cmp++; if (RTY !== 1'b0) begin n_fail++; $display("FAIL rst_rty: got %b expected 0", RTY); end
        repeat (10) @(negedge clk);
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'd10) begin n_fail++; $display("FAIL idle_mtime_lo: got %0d expected 10", rd); end
        n_cmp++; if (a1 !== 1'b1 || e1 !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got ack=%b err=%b expected 1/0", a1, e1); end
        bus(0, 32'h08, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp_lo: got %h expected ffffffff", rd); end
        bus(0, 32'h0C, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp_hi: got %h expected ffffffff", rd); end
        bus(0, 32'h10, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 1", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL idle_irq: got %b expected 0", irq); end
    endtask

    task automatic test_prescale();
        logic [31:0] v1;
        bus(1, 32'h10, 32'h0000_0301, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b%b expected 10", a1, a2); end
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        v1 = rd;
        n_cmp++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse: got %b%b expected 10", a1, a2); end
        repeat (16) @(negedge clk);
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd - v1 !== 32'd4) begin n_fail++; $display("FAIL prescale_delta: got %0d expected 4", rd - v1); end
        bus(0, 32'h10, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h0000_0301) begin n_fail++; $display("FAIL ctrl_rb: got %h expected 00000301", rd); end
    endtask

    task automatic test_irq();
        bus(1, 32'h10, 32'h0, rd, a1, e1, a2, e2, i1, i2);
        bus(1, 32'h00, 32'h0, rd, a1, e1, a2, e2, i1, i2);
        bus(1, 32'h04, 32'h0, rd, a1, e1, a2, e2, i1, i2);
        bus(1, 32'h0C, 32'h0, rd, a1, e1, a2, e2, i1, i2);
        bus(1, 32'h08, 32'd20, rd, a1, e1, a2, e2, i1, i2);
        // CTRL written at edge C; mtime == 20 after C+20, irq registered at C+21.
        bus(1, 32'h10, 32'h3, rd, a1, e1, a2, e2, i1, i2);
        repeat (19) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq); end
        bus(1, 32'h08, 32'hFFFF_FFFF, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (i1 !== 1'b1) begin n_fail++; $display("FAIL irq_hold_at_wr: got %b expected 1", i1); end
        n_cmp++; if (i2 !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", i2); end
    endtask

    task automatic test_snapshot();
        bus(1, 32'h04, 32'h1, rd, a1, e1, a2, e2, i1, i2);
        bus(1, 32'h00, 32'hFFFF_FFFE, rd, a1, e1, a2, e2, i1, i2);
        repeat (5) @(negedge clk);
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'd4) begin n_fail++; $display("FAIL snap_lo: got %h expected 00000004", rd); end
        bus(0, 32'h04, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL snap_hi: got %h expected 00000002", rd); end
    endtask

    task automatic test_error();
        bus(0, 32'h14, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (e1 !== 1'b1 || e2 !== 1'b0) begin n_fail++; $display("FAIL err_14_pulse: got %b%b expected 10", e1, e2); end
        n_cmp++; if (a1 !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL err_14_ack_dat: got ack=%b dat=%h expected 0/0", a1, rd); end
        bus(0, 32'h02, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (e1 !== 1'b1 || a1 !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL err_02: got err=%b ack=%b dat=%h expected 1/0/0", e1, a1, rd); end
        bus(1, 32'h12, 32'h0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL err_wr_12: got %b expected 1", e1); end
        bus(0, 32'h10, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL err_no_write: got %h expected 00000003", rd); end
    endtask

    task automatic test_write_tick();
        // div = 0 ticks every edge, so the write edge is always a tick edge.
        bus(1, 32'h00, 32'h100, rd, a1, e1, a2, e2, i1, i2);
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h101) begin n_fail++; $display("FAIL wr_tick_held: got %h expected 00000101", rd); end
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h103) begin n_fail++; $display("FAIL wr_tick_resume: got %h expected 00000103", rd); end
        bus(0, 32'h04, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL wr_tick_hi: got %h expected 00000002", rd); end
    endtask

    task automatic test_ctrl_hold();
        bus(1, 32'h10, 32'hFFFF_FFFF, rd, a1, e1, a2, e2, i1, i2);
        bus(0, 32'h10, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h0000_FF03) begin n_fail++; $display("FAIL ctrl_mask: got %h expected 0000ff03", rd); end
        bus(1, 32'h10, 32'h2, rd, a1, e1, a2, e2, i1, i2);
        bus(1, 32'h00, 32'h77, rd, a1, e1, a2, e2, i1, i2);
        repeat (4) @(negedge clk);
        bus(0, 32'h00, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h77) begin n_fail++; $display("FAIL cnt_hold: got %h expected 00000077", rd); end
    endtask

    task automatic test_reset_mid();
        STB = 1'b1; CYC = 1'b1; WE = 1'b1; ADR = 32'h08; DAT_I = 32'h55;
        @(posedge clk); #1;
        n_cmp++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL mid_ack_before: got %b expected 1", ACK); end
        rst = 1'b1; #1;
        n_cmp++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL mid_ack_cleared: got %b expected 0", ACK); end
        STB = 1'b0; CYC = 1'b0; WE = 1'b0; ADR = '0; DAT_I = '0;
        @(negedge clk);
        rst = 1'b0;
        bus(0, 32'h10, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL mid_ctrl_reset: got %h expected 00000001", rd); end
        bus(0, 32'h08, 0, rd, a1, e1, a2, e2, i1, i2);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_cmp_reset: got %h expected ffffffff", rd); end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_irq();
        test_snapshot();
        test_error();
        test_write_tick();
        test_ctrl_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
